// File: rtl/adjust_color_stream_bridge_pkg.sv
// Shared definitions for the colour-adjust pipeline and its stream bridge.
// Both import this package, so the pipeline latency is defined in one place.
package adjust_color_stream_bridge_pkg;

  localparam int unsigned ADJ_LATENCY = 26;
  localparam int unsigned PIXEL_W     = 24;
  localparam int unsigned ENTRY_W     = PIXEL_W + 2;

  typedef logic [PIXEL_W-1:0] pixel_t;

  // Sideband token carried alongside each pixel through the pipeline delay.
  typedef struct packed {
    logic tok;
    logic user;
    logic last;
  } sb_token_t;

  function automatic sb_token_t make_token(input logic tok, input logic user, input logic last);
    sb_token_t t;
    t.tok  = tok;
    t.user = user;
    t.last = last;
    return t;
  endfunction

endpackage

// File: rtl/adjust_color_stream_bridge_fifo.sv
// First-word-fall-through synchronous FIFO with wrap-bit pointers.
// The head entry is always visible on rd_data_o while the FIFO is non-empty.
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 26,
  parameter int unsigned DEPTH = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = (AW+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             do_wr, do_rd;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_wr   = wr_en_i & ~full_o;
  assign do_rd   = rd_en_i & ~empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_wr) wptr_d = wptr_q + PtrOne;
    if (do_rd) rptr_d = rptr_q + PtrOne;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: entries are only observed between the pointers.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wptr_q[AW-1:0]] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/adjust_color_stream_bridge.sv
// AXI4-Stream bridge around the fixed-latency colour-adjust pipeline.
// Credits reserve FIFO space at accept time so pipeline results can never be dropped.
module adjust_color_stream_bridge
  import adjust_color_stream_bridge_pkg::*;
#(
  parameter int unsigned LATENCY    = ADJ_LATENCY,
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned ADDR_W     = 6
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [PIXEL_W-1:0] s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  input  logic               s_axis_tuser,
  input  logic               s_axis_tlast,
  output logic [PIXEL_W-1:0] pixel_m_data,
  output logic               pixel_m_valid,
  input  logic [PIXEL_W-1:0] res_s_data,
  input  logic               res_s_valid,
  output logic [PIXEL_W-1:0] m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tuser,
  output logic               m_axis_tlast,
  output logic               err_overflow,
  output logic               err_align
);

  localparam logic [ADDR_W:0] DepthCnt = (ADDR_W+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0] CntOne   = (ADDR_W+1)'(1);

  logic [ADDR_W:0]    reserved_q, reserved_d;
  logic               ready_q;
  logic               accept, pop;
  sb_token_t          dly_q [LATENCY];
  sb_token_t          dly_out;
  logic               wr_req, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] fifo_head;
  logic               err_overflow_q, err_align_q;

  assign accept        = s_axis_tvalid & ready_q;
  assign pop           = m_axis_tvalid & m_axis_tready;
  assign s_axis_tready = ready_q;
  assign pixel_m_valid = accept;
  assign pixel_m_data  = s_axis_tdata;

  always_comb begin
    reserved_d = reserved_q;
    unique case ({accept, pop})
      2'b10:   reserved_d = reserved_q + CntOne;
      2'b01:   reserved_d = reserved_q - CntOne;
      default: reserved_d = reserved_q;
    endcase
  end

  // Ready is registered from the next credit count so it holds 0 throughout reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      reserved_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      reserved_q <= reserved_d;
      ready_q    <= (reserved_d < DepthCnt);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(LATENCY); i++) dly_q[i] <= '0;
    end else begin
      dly_q[0] <= make_token(accept, s_axis_tuser, s_axis_tlast);
      for (int i = 1; i < int'(LATENCY); i++) dly_q[i] <= dly_q[i-1];
    end
  end

  assign dly_out = dly_q[LATENCY-1];
  assign wr_req  = res_s_valid & dly_out.tok;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_overflow_q <= 1'b0;
      err_align_q    <= 1'b0;
    end else begin
      err_overflow_q <= err_overflow_q | (wr_req & fifo_full);
      err_align_q    <= err_align_q | (res_s_valid ^ dly_out.tok);
    end
  end

  assign err_overflow = err_overflow_q;
  assign err_align    = err_align_q;

  sync_fifo_fwft #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk),
    .rst_ni    (resetn),
    .wr_en_i   (wr_req),
    .wr_data_i ({dly_out.user, dly_out.last, res_s_data}),
    .rd_en_i   (pop),
    .rd_data_o (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Head fields are masked while empty so sideband outputs read 0 when idle.
  assign m_axis_tvalid = ~fifo_empty;
  assign m_axis_tdata  = fifo_empty ? '0   : fifo_head[PIXEL_W-1:0];
  assign m_axis_tlast  = fifo_empty ? 1'b0 : fifo_head[PIXEL_W];
  assign m_axis_tuser  = fifo_empty ? 1'b0 : fifo_head[PIXEL_W+1];

endmodule

// File: tb/tb_adjust_color_stream_bridge.sv
// Directed bench for adjust_color_stream_bridge with a bit-invert loopback pipeline model.
module tb_adjust_color_stream_bridge;

  localparam int LAT = 26;

  logic        clk = 1'b0;
  logic        resetn;
  logic [23:0] s_tdata;
  logic        s_tvalid, s_tready, s_tuser, s_tlast;
  logic [23:0] pixel_m_data;
  logic        pixel_m_valid;
  logic [23:0] res_s_data;
  logic        res_s_valid;
  logic [23:0] m_tdata;
  logic        m_tvalid, m_tready, m_tuser, m_tlast;
  logic        err_overflow, err_align;
  logic        inj;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int pop_cnt = 0;
  int first_pop = -1;
  int last_pop = -1;
  logic last_acc = 1'b0;
  logic stall_q = 1'b0;
  logic [31:0] stall_word = '0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  adjust_color_stream_bridge dut (
    .clk           (clk),
    .resetn        (resetn),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tuser  (s_tuser),
    .s_axis_tlast  (s_tlast),
    .pixel_m_data  (pixel_m_data),
    .pixel_m_valid (pixel_m_valid),
    .res_s_data    (res_s_data),
    .res_s_valid   (res_s_valid),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tuser  (m_tuser),
    .m_axis_tlast  (m_tlast),
    .err_overflow  (err_overflow),
    .err_align     (err_align)
  );

  // Loopback pipeline: LAT-cycle delay, result = bitwise inverse of the pixel.
  logic [23:0] pd [LAT];
  logic        pv [LAT];
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < LAT; i++) begin
        pd[i] <= '0;
        pv[i] <= 1'b0;
      end
    end else begin
      pd[0] <= ~pixel_m_data;
      pv[0] <= pixel_m_valid;
      for (int i = 1; i < LAT; i++) begin
        pd[i] <= pd[i-1];
        pv[i] <= pv[i-1];
      end
    end
  end
  assign res_s_data  = pd[LAT-1];
  assign res_s_valid = pv[LAT-1] | inj;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes on the falling edge, then return 1 time unit after the rise.
  task automatic tick();
    logic acc, pop;
    logic [31:0] word, exp;
    @(negedge clk);
    acc  = s_tvalid & s_tready;
    pop  = m_tvalid & m_tready;
    word = {6'd0, m_tuser, m_tlast, m_tdata};
    if (stall_q) begin
      chk("stall_valid", 32'(m_tvalid), 32'd1);
      chk("stall_data", word, stall_word);
    end
    if (pop) begin
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      chk("pop_data", word, exp);
      pop_cnt++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
    if (acc) begin
      exp_q.push_back({6'd0, s_tuser, s_tlast, ~s_tdata});
      acc_cnt++;
    end
    last_acc   = acc;
    stall_q    = m_tvalid & ~m_tready;
    stall_word = word;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int g;
    int blocked_at;
    logic [23:0] d;
    resetn   = 1'b0;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b0;
    inj      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tready", 32'(s_tready), 32'd0);
    chk("rst_mvalid", 32'(m_tvalid), 32'd0);
    chk("rst_pvalid", 32'(pixel_m_valid), 32'd0);
    chk("rst_flags", {28'd0, m_tuser, m_tlast, err_overflow, err_align}, 32'd0);
    resetn = 1'b1;
    tick();
    chk("rel_tready", 32'(s_tready), 32'd1);

    // Single pixel latency: valid appears on the 27th edge after acceptance.
    s_tvalid = 1'b1; s_tdata = 24'h123456; s_tuser = 1'b1; s_tlast = 1'b0;
    tick();
    s_tvalid = 1'b0; s_tuser = 1'b0;
    repeat (25) tick();
    chk("t1_not_yet", 32'(m_tvalid), 32'd0);
    tick();
    chk("t1_valid", 32'(m_tvalid), 32'd1);
    chk("t1_data", 32'(m_tdata), 32'h00EDCBA9);
    chk("t1_user", 32'(m_tuser), 32'd1);
    chk("t1_last", 32'(m_tlast), 32'd0);
    m_tready = 1'b1;
    tick();
    chk("t1_empty", 32'(m_tvalid), 32'd0);

    // Backpressure: only FIFO_DEPTH pixels may be in flight or buffered.
    m_tready = 1'b0; acc_cnt = 0; blocked_at = -1; d = 24'h000100;
    s_tvalid = 1'b1; s_tdata = d;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (last_acc) begin d = d + 24'd1; s_tdata = d; end
      if (!s_tready && blocked_at < 0) blocked_at = acc_cnt;
    end
    s_tvalid = 1'b0;
    chk("t2_accepted", 32'(acc_cnt), 32'd64);
    chk("t2_block_point", 32'(blocked_at), 32'd64);
    chk("t2_tready_low", 32'(s_tready), 32'd0);
    chk("t2_overflow", 32'(err_overflow), 32'd0);
    m_tready = 1'b1; pop_cnt = 0;
    tick();
    chk("t2_ready_on_pop", 32'(s_tready), 32'd1);
    repeat (79) tick();
    chk("t2_drained", 32'(pop_cnt), 32'd64);

    // Full-rate line with tlast on its final pixel.
    pop_cnt = 0; first_pop = -1;
    for (int i = 0; i < 200; i++) begin
      s_tvalid = 1'b1; s_tdata = 24'h400000 + 24'(i);
      s_tuser = (i == 0); s_tlast = (i == 199);
      tick();
      chk("t3_ready", 32'(s_tready), 32'd1);
    end
    s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
    repeat (40) tick();
    chk("t3_count", 32'(pop_cnt), 32'd200);
    chk("t3_back_to_back", 32'(last_pop - first_pop), 32'd199);

    // Simultaneous accept and pop at 63 credits leaves ready asserted.
    m_tready = 1'b0; acc_cnt = 0; g = 0; d = 24'h500000;
    s_tvalid = 1'b1; s_tdata = d;
    while (acc_cnt < 63 && g < 200) begin
      tick(); g++;
      if (last_acc) begin d = d + 24'd1; s_tdata = d; end
    end
    s_tvalid = 1'b0;
    repeat (30) tick();
    chk("t5_ready_at_63", 32'(s_tready), 32'd1);
    s_tvalid = 1'b1; s_tdata = 24'h5A0001; m_tready = 1'b1;
    tick();
    s_tvalid = 1'b0; m_tready = 1'b0;
    chk("t5_ready_held", 32'(s_tready), 32'd1);
    s_tvalid = 1'b1; s_tdata = 24'h5A0002;
    tick();
    s_tvalid = 1'b0;
    chk("t5_ready_at_64", 32'(s_tready), 32'd0);
    repeat (30) tick();
    m_tready = 1'b1; pop_cnt = 0;
    repeat (80) tick();
    chk("t5_drained", 32'(pop_cnt), 32'd64);
    chk("t5_queue_empty", 32'(exp_q.size()), 32'd0);

    // Random source and sink; scoreboard and stall checks run inside tick().
    acc_cnt = 0; g = 0; s_tvalid = 1'b0;
    while (acc_cnt < 500 && g < 5000) begin
      if (!s_tvalid || last_acc) begin
        s_tvalid = 1'($urandom_range(0, 1));
        s_tdata  = 24'($urandom);
        s_tuser  = 1'($urandom_range(0, 1));
        s_tlast  = 1'($urandom_range(0, 1));
      end
      m_tready = 1'($urandom_range(0, 1));
      tick(); g++;
    end
    s_tvalid = 1'b0; m_tready = 1'b1;
    repeat (150) tick();
    chk("t4_accepted", 32'(acc_cnt), 32'd500);
    chk("t4_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("t4_errs", {30'd0, err_overflow, err_align}, 32'd0);

    // Result valid one cycle before its token: flagged and sticky.
    s_tvalid = 1'b1; s_tdata = 24'hABCDEF; s_tuser = 1'b0; s_tlast = 1'b1;
    tick();
    s_tvalid = 1'b0; s_tlast = 1'b0;
    repeat (LAT - 2) tick();
    inj = 1'b1;
    tick();
    inj = 1'b0;
    repeat (5) tick();
    chk("t6_align", 32'(err_align), 32'd1);
    chk("t6_overflow", 32'(err_overflow), 32'd0);
    chk("t6_delivered", 32'(exp_q.size()), 32'd0);

    // Mid-stream reset discards everything buffered or in flight.
    m_tready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      s_tvalid = 1'b1; s_tdata = 24'h600000 + 24'(i);
      tick();
    end
    s_tvalid = 1'b0;
    repeat (25) tick();
    chk("t6_pre_rst_valid", 32'(m_tvalid), 32'd1);
    s_tvalid = 1'b1;
    resetn = 1'b0;
    #1;
    chk("t6_rst_tready", 32'(s_tready), 32'd0);
    chk("t6_rst_pvalid", 32'(pixel_m_valid), 32'd0);
    chk("t6_rst_mvalid", 32'(m_tvalid), 32'd0);
    chk("t6_rst_flags", {28'd0, m_tuser, m_tlast, err_overflow, err_align}, 32'd0);
    exp_q.delete();
    stall_q = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    resetn = 1'b1;
    m_tready = 1'b1; pop_cnt = 0;
    repeat (40) tick();
    chk("t6_no_output", 32'(pop_cnt), 32'd0);
    chk("t6_idle_valid", 32'(m_tvalid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
